// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI burst writer: FSM states, status codes,
// AXI burst/response encodings and the 4 KB page size that bursts may not cross.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_RESP  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  localparam logic [2:0] STATUS_IDLE  = 3'b000;
  localparam logic [2:0] STATUS_BUSY  = 3'b001;
  localparam logic [2:0] STATUS_DONE  = 3'b010;
  localparam logic [2:0] STATUS_ERROR = 3'b100;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

  // SLVERR and DECERR both have the upper response bit set.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beats for the next burst: the smallest of words remaining, the burst limit
// and the beats that still fit before the next 4 KB page boundary.
module axi_burst_len_calc
  import axi_burst_pkg::*;
#(
  parameter int CNT_WIDTH = 3,
  parameter int SIZE_LOG2 = 2,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0]          page_offset_i,
  input  logic [CNT_WIDTH-1:0] remaining_i,
  output logic [8:0]           beats_o
);

  logic [12:0] to_boundary_s;
  logic [31:0] cand_s;
  logic [31:0] beats_s;

  // Three-way minimum of remaining words, burst limit and page room.
  always_comb begin
    to_boundary_s = (BOUNDARY_4K - {1'b0, page_offset_i}) >> SIZE_LOG2;
    if (32'(remaining_i) < 32'(MAX_BURST)) begin
      cand_s = 32'(remaining_i);
    end else begin
      cand_s = 32'(MAX_BURST);
    end
    if (cand_s < 32'(to_boundary_s)) begin
      beats_s = cand_s;
    end else begin
      beats_s = 32'(to_boundary_s);
    end
    beats_o = 9'(beats_s);
  end

endmodule

// File: rtl/axi_burst_writer.sv
// Writes a bank of source words to memory as a sequence of AXI INCR bursts,
// one burst outstanding at a time, reporting idle/busy/done/error status.
module axi_burst_writer
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WORDS      = 6,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 areset,
  input  logic [WORDS-1:0][DATA_WIDTH-1:0]     regs_i,
  input  logic [ADDR_WIDTH-1:0]                base_addr_i,
  input  logic [$clog2(WORDS+1)-1:0]           word_count_i,
  input  logic                                 start_i,
  output logic [2:0]                           status_o,
  input  logic                                 status_read_i,
  output logic [ID_WIDTH-1:0]                  awid_o,
  output logic [ADDR_WIDTH-1:0]                awaddr_o,
  output logic [7:0]                           awlen_o,
  output logic [2:0]                           awsize_o,
  output logic [1:0]                           awburst_o,
  output logic                                 awvalid_o,
  input  logic                                 awready_i,
  output logic [ID_WIDTH-1:0]                  wid_o,
  output logic [DATA_WIDTH-1:0]                wdata_o,
  output logic [DATA_WIDTH/8-1:0]              wstrb_o,
  output logic                                 wlast_o,
  output logic                                 wvalid_o,
  input  logic                                 wready_i,
  input  logic [ID_WIDTH-1:0]                  bid_i,
  input  logic [1:0]                           bresp_i,
  input  logic                                 bvalid_i,
  output logic                                 bready_o
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam int CW        = $clog2(WORDS + 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]           remaining_q, remaining_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [8:0]              burst_beats_q, burst_beats_d;
  logic [8:0]              beats_left_q, beats_left_d;
  logic [2:0]              status_q, status_d;
  logic                    awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic                    wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wlast_q, wlast_d;
  logic                    bready_q, bready_d;

  logic [ADDR_WIDTH-1:0]   calc_addr_s;
  logic [CW-1:0]           calc_rem_s;
  logic [8:0]              calc_beats_s;
  logic [CW-1:0]           next_idx_s;
  logic [DATA_WIDTH-1:0]   next_word_s;
  logic                    bad_job_s;
  logic                    bid_unused_s;

  // Only one burst is ever outstanding, so the response ID carries no information.
  assign bid_unused_s = ^bid_i;

  // Length calculator sees the new job in IDLE and the post-burst position otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      calc_addr_s = base_addr_i;
      calc_rem_s  = word_count_i;
    end else begin
      calc_addr_s = addr_q + (ADDR_WIDTH'(burst_beats_q) << SIZE_LOG2);
      calc_rem_s  = remaining_q - CW'(burst_beats_q);
    end
  end

  axi_burst_len_calc #(
    .CNT_WIDTH (CW),
    .SIZE_LOG2 (SIZE_LOG2),
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .page_offset_i (calc_addr_s[11:0]),
    .remaining_i   (calc_rem_s),
    .beats_o       (calc_beats_s)
  );

  // Word to present on the next W beat and job validity check.
  always_comb begin
    if (state_q == S_ADDR) begin
      next_idx_s = idx_q;
    end else begin
      next_idx_s = idx_q + CW'(1'b1);
    end
    if (next_idx_s < CW'(WORDS)) begin
      next_word_s = regs_i[next_idx_s];
    end else begin
      next_word_s = {DATA_WIDTH{1'b0}};
    end
    bad_job_s = (word_count_i == {CW{1'b0}}) ||
                (32'(word_count_i) > 32'(WORDS)) ||
                (|base_addr_i[SIZE_LOG2-1:0]);
  end

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    idx_d         = idx_q;
    burst_beats_d = burst_beats_q;
    beats_left_d  = beats_left_q;
    status_d      = status_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    wvalid_d      = wvalid_q;
    wdata_d       = wdata_q;
    wlast_d       = wlast_q;
    bready_d      = bready_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (bad_job_s) begin
            state_d  = S_ERROR;
            status_d = STATUS_ERROR;
          end else begin
            state_d       = S_ADDR;
            status_d      = STATUS_BUSY;
            addr_d        = base_addr_i;
            remaining_d   = word_count_i;
            idx_d         = {CW{1'b0}};
            burst_beats_d = calc_beats_s;
            awvalid_d     = 1'b1;
            awaddr_d      = base_addr_i;
            awlen_d       = 8'(calc_beats_s - 9'd1);
          end
        end else begin
          status_d = STATUS_IDLE;
        end
      end
      S_ADDR: begin
        if (awready_i) begin
          state_d      = S_DATA;
          awvalid_d    = 1'b0;
          wvalid_d     = 1'b1;
          wdata_d      = next_word_s;
          wlast_d      = (burst_beats_q == 9'd1);
          beats_left_d = burst_beats_q;
        end else begin
          awvalid_d = 1'b1;
        end
      end
      S_DATA: begin
        if (wready_i) begin
          idx_d        = idx_q + CW'(1'b1);
          beats_left_d = beats_left_q - 9'd1;
          if (wlast_q) begin
            state_d  = S_RESP;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            wdata_d = next_word_s;
            wlast_d = (beats_left_q == 9'd2);
          end
        end else begin
          wvalid_d = 1'b1;
        end
      end
      S_RESP: begin
        if (bvalid_i) begin
          bready_d = 1'b0;
          if (resp_is_error(bresp_i)) begin
            state_d  = S_ERROR;
            status_d = STATUS_ERROR;
          end else begin
            addr_d      = calc_addr_s;
            remaining_d = calc_rem_s;
            if (calc_rem_s == {CW{1'b0}}) begin
              state_d  = S_DONE;
              status_d = STATUS_DONE;
            end else begin
              state_d       = S_ADDR;
              awvalid_d     = 1'b1;
              awaddr_d      = calc_addr_s;
              awlen_d       = 8'(calc_beats_s - 9'd1);
              burst_beats_d = calc_beats_s;
            end
          end
        end else begin
          bready_d = 1'b1;
        end
      end
      S_DONE, S_ERROR: begin
        if (status_read_i) begin
          state_d  = S_IDLE;
          status_d = STATUS_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        status_d  = STATUS_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        wlast_d   = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset takes effect without waiting for clk.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= S_IDLE;
      addr_q        <= {ADDR_WIDTH{1'b0}};
      remaining_q   <= {CW{1'b0}};
      idx_q         <= {CW{1'b0}};
      burst_beats_q <= 9'd0;
      beats_left_q  <= 9'd0;
      status_q      <= STATUS_IDLE;
      awvalid_q     <= 1'b0;
      awaddr_q      <= {ADDR_WIDTH{1'b0}};
      awlen_q       <= 8'd0;
      wvalid_q      <= 1'b0;
      wdata_q       <= {DATA_WIDTH{1'b0}};
      wlast_q       <= 1'b0;
      bready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      idx_q         <= idx_d;
      burst_beats_q <= burst_beats_d;
      beats_left_q  <= beats_left_d;
      status_q      <= status_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      wvalid_q      <= wvalid_d;
      wdata_q       <= wdata_d;
      wlast_q       <= wlast_d;
      bready_q      <= bready_d;
    end
  end

  assign status_o  = status_q;
  assign awid_o    = {ID_WIDTH{1'b0}};
  assign awaddr_o  = awaddr_q;
  assign awlen_o   = awlen_q;
  assign awsize_o  = 3'(SIZE_LOG2);
  assign awburst_o = BURST_INCR;
  assign awvalid_o = awvalid_q;
  assign wid_o     = {ID_WIDTH{1'b0}};
  assign wdata_o   = wdata_q;
  assign wstrb_o   = {BYTES{1'b1}};
  assign wlast_o   = wlast_q;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Self-checking bench for axi_burst_writer: directed and random jobs against a
// burst-splitting reference model, with an AXI slave responder and bus monitor.
module tb_axi_burst_writer;
  import axi_burst_pkg::*;

  localparam int DW = 32, AW = 32, WORDS = 6, MB = 4, IDW = 4;

  logic                        clk = 1'b0;
  logic                        areset;
  logic [WORDS-1:0][DW-1:0]    regs;
  logic [AW-1:0]               base_addr_i;
  logic [2:0]                  word_count_i;
  logic                        start_i, status_read_i;
  logic [2:0]                  status_o;
  logic [IDW-1:0]              awid_o, wid_o;
  logic [AW-1:0]               awaddr_o;
  logic [7:0]                  awlen_o;
  logic [2:0]                  awsize_o;
  logic [1:0]                  awburst_o;
  logic                        awvalid_o, awready_i;
  logic [DW-1:0]               wdata_o;
  logic [DW/8-1:0]             wstrb_o;
  logic                        wlast_o, wvalid_o, wready_i;
  logic [IDW-1:0]              bid_i;
  logic [1:0]                  bresp_i;
  logic                        bvalid_i, bready_o;

  always #5 clk = ~clk;

  axi_burst_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS(WORDS), .MAX_BURST(MB), .ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .areset(areset), .regs_i(regs), .base_addr_i(base_addr_i),
    .word_count_i(word_count_i), .start_i(start_i), .status_o(status_o),
    .status_read_i(status_read_i), .awid_o(awid_o), .awaddr_o(awaddr_o),
    .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .wid_o(wid_o), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  int total = 0, bad = 0;
  int aw_delay, w_mode, aw_wait, b_count;
  logic [1:0] resp_arr [8];
  logic [31:0] awq_addr[$];
  logic [7:0]  awq_len[$];
  logic [31:0] wq_data[$];
  logic        wq_last[$];
  int stab_err, overlap_err, fixed_err;
  logic aw_pend, w_pend;
  logic [31:0] aw_prev_addr, w_prev_data;
  logic [7:0]  aw_prev_len;

  // Slave responder: drives ready/response inputs away from the active edge.
  always @(negedge clk) begin
    if (awvalid_o) begin
      if (aw_wait >= aw_delay) awready_i = 1'b1;
      else begin awready_i = 1'b0; aw_wait++; end
    end else begin
      awready_i = 1'b0;
      aw_wait = 0;
    end
    case (w_mode)
      0: wready_i = 1'b1;
      1: wready_i = ~wready_i;
      default: wready_i = 1'($urandom_range(0, 1));
    endcase
    bvalid_i = bready_o;
    bresp_i  = (b_count < 8) ? resp_arr[b_count] : RESP_OKAY;
  end

  // Bus monitor: records handshakes and protocol-rule violations.
  always @(posedge clk) begin
    if (areset) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else begin
      if (aw_pend && (!awvalid_o || awaddr_o != aw_prev_addr || awlen_o != aw_prev_len)) stab_err <= stab_err + 1;
      if (w_pend && (!wvalid_o || wdata_o != w_prev_data)) stab_err <= stab_err + 1;
      if (awvalid_o && wvalid_o) overlap_err <= overlap_err + 1;
      if (awvalid_o && (awsize_o != 3'd2 || awburst_o != 2'b01 || awid_o != 4'd0)) fixed_err <= fixed_err + 1;
      if (wvalid_o && (wstrb_o != 4'hF || wid_o != 4'd0)) fixed_err <= fixed_err + 1;
      if (awvalid_o && awready_i) begin awq_addr.push_back(awaddr_o); awq_len.push_back(awlen_o); end
      if (wvalid_o && wready_i) begin wq_data.push_back(wdata_o); wq_last.push_back(wlast_o); end
      if (bvalid_i && bready_o) b_count <= b_count + 1;
      aw_pend      <= awvalid_o && !awready_i;
      w_pend       <= wvalid_o && !wready_i;
      aw_prev_addr <= awaddr_o;
      aw_prev_len  <= awlen_o;
      w_prev_data  <= wdata_o;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one job and compares the observed bus traffic with the model's burst plan.
  task automatic run_job(input logic [31:0] base, input int cnt, input int awd,
                         input int wm, input bit hold, input string tag);
    logic [31:0] e_addr[$];
    int          e_len[$];
    logic [31:0] e_data[$];
    bit          e_last[$];
    logic [2:0]  e_status;
    logic [31:0] a;
    int rem, k, nb, to4k, idx, n;
    for (int i = 0; i < WORDS; i++) regs[i] = $urandom;
    aw_delay = awd; w_mode = wm; b_count = 0;
    stab_err = 0; overlap_err = 0; fixed_err = 0;
    awq_addr.delete(); awq_len.delete(); wq_data.delete(); wq_last.delete();
    if (cnt == 0 || cnt > WORDS || base[1:0] != 2'b00) begin
      e_status = STATUS_ERROR;
    end else begin
      e_status = STATUS_DONE; a = base; rem = cnt; k = 0; idx = 0;
      while (rem > 0) begin
        to4k = (4096 - int'(a & 32'hFFF)) / 4;
        nb = rem;
        if (nb > MB) nb = MB;
        if (nb > to4k) nb = to4k;
        e_addr.push_back(a); e_len.push_back(nb - 1);
        for (int j = 0; j < nb; j++) begin
          e_data.push_back(regs[idx]); e_last.push_back(j == nb - 1); idx++;
        end
        if (resp_arr[k][1]) begin e_status = STATUS_ERROR; rem = 0; end
        else begin a = a + 32'(nb * 4); rem = rem - nb; k++; end
      end
    end
    base_addr_i = base; word_count_i = 3'(cnt); start_i = 1'b1;
    @(negedge clk);
    if (hold) base_addr_i = 32'h0000_0003;
    else start_i = 1'b0;
    if (e_addr.size() == 0) begin
      chk({tag, ".early_status"}, status_o, STATUS_ERROR);
      chk({tag, ".early_awvalid"}, awvalid_o, 1'b0);
    end else begin
      chk({tag, ".busy"}, status_o, STATUS_BUSY);
    end
    n = 0;
    while (status_o == STATUS_BUSY && n < 400) begin @(negedge clk); n++; end
    chk({tag, ".timeout"}, n < 400, 1'b1);
    start_i = 1'b0;
    chk({tag, ".status"}, status_o, e_status);
    chk({tag, ".aw_count"}, awq_addr.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < awq_addr.size(); i++) begin
      chk({tag, ".awaddr"}, awq_addr[i], e_addr[i]);
      chk({tag, ".awlen"}, awq_len[i], e_len[i]);
    end
    chk({tag, ".w_count"}, wq_data.size(), e_data.size());
    for (int i = 0; i < e_data.size() && i < wq_data.size(); i++) begin
      chk({tag, ".wdata"}, wq_data[i], e_data[i]);
      chk({tag, ".wlast"}, wq_last[i], e_last[i]);
    end
    chk({tag, ".stable"}, stab_err, 0);
    chk({tag, ".overlap"}, overlap_err, 0);
    chk({tag, ".fixed"}, fixed_err, 0);
    status_read_i = 1'b1;
    @(negedge clk);
    status_read_i = 1'b0;
    chk({tag, ".cleared"}, status_o, STATUS_IDLE);
  endtask

  initial begin
    int n, nw;
    logic [31:0] base;
    areset = 1'b1; start_i = 1'b0; status_read_i = 1'b0; base_addr_i = 32'h0;
    word_count_i = 3'd0; bid_i = 4'd0; regs = '0; wready_i = 1'b0;
    aw_delay = 0; w_mode = 0; aw_wait = 0; b_count = 0;
    stab_err = 0; overlap_err = 0; fixed_err = 0;
    for (int i = 0; i < 8; i++) resp_arr[i] = RESP_OKAY;
    #12;
    chk("rst.status", status_o, STATUS_IDLE);
    chk("rst.awvalid", awvalid_o, 1'b0);
    chk("rst.wvalid", wvalid_o, 1'b0);
    chk("rst.bready", bready_o, 1'b0);
    chk("rst.awaddr", awaddr_o, 32'h0);
    chk("rst.awlen", awlen_o, 8'h0);
    @(negedge clk); areset = 1'b0;
    @(negedge clk);

    run_job(32'h0000_1000, 6, 0, 0, 1'b0, "basic");
    run_job(32'h0000_0FF8, 4, 0, 0, 1'b0, "cross4k");
    run_job(32'h0000_2000, 6, 5, 1, 1'b0, "slow");
    resp_arr[0] = RESP_SLVERR;
    run_job(32'h0000_1000, 6, 0, 0, 1'b0, "slverr");
    resp_arr[0] = RESP_OKAY;
    run_job(32'h0000_1000, 0, 0, 0, 1'b0, "cnt0");
    run_job(32'h0000_1002, 4, 0, 0, 1'b0, "misalign");
    run_job(32'h0000_1000, 7, 0, 0, 1'b0, "cnt7");

    // Reset in the middle of a data phase.
    for (int i = 0; i < WORDS; i++) regs[i] = $urandom;
    aw_delay = 0; w_mode = 1;
    base_addr_i = 32'h0000_3000; word_count_i = 3'd6; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (!wvalid_o && n < 50) begin @(negedge clk); n++; end
    chk("mid.reach_data", n < 50, 1'b1);
    @(negedge clk);
    #2 areset = 1'b1;
    #1;
    chk("mid.awvalid", awvalid_o, 1'b0);
    chk("mid.wvalid", wvalid_o, 1'b0);
    chk("mid.wlast", wlast_o, 1'b0);
    chk("mid.bready", bready_o, 1'b0);
    chk("mid.status", status_o, STATUS_IDLE);
    @(negedge clk); areset = 1'b0;
    nw = wq_data.size();
    repeat (10) @(negedge clk);
    chk("mid.no_more_beats", wq_data.size(), nw);
    chk("mid.idle_after", status_o, STATUS_IDLE);
    run_job(32'h0000_3000, 6, 0, 0, 1'b0, "after_rst");

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 8; k++)
        resp_arr[k] = ($urandom_range(0, 5) == 0) ? RESP_DECERR :
                      ($urandom_range(0, 1) == 1) ? RESP_EXOKAY : RESP_OKAY;
      base = ($urandom & 32'hFFFF_F000) | (32'h1000 - 32'(4 * $urandom_range(1, 12)));
      run_job(base, $urandom_range(1, 6), $urandom_range(0, 3), 2, r[0], "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
